// File: rtl/vslc_timer_bank.sv
// -----------------------------------------------------------------------------
// vslc_timer_bank
//   Multi-channel timer bank for the VSLC bit-serial logic controller. Each
//   channel owns two phase periods, a power-of-two prescaler and one of four
//   modes: CYCLE, ONESHOT, TON (on-delay) or TOF (off-delay).
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   cfg_we     config write strobe
//   cfg_sel    channel select (values >= NUM_TIMERS ignored, read as 0)
//   cfg_addr   0=period_a 1=period_b 2={div,mode} 3=status (read only)
//   cfg_wdata  write data; addr2 takes div from [DIV_W+1:2], mode from [1:0]
//   cfg_rdata  registered readback of the {sel,addr} presented last cycle
//   en_set     per-channel enable pulse
//   en_clr     per-channel disable pulse (wins over en_set)
//   gate       per-channel level input used by TON/TOF
//   tmr_out    timer output levels
//   active     channel enabled and currently timing
//   done       one-clock pulse at the end of a timing event
// -----------------------------------------------------------------------------
module vslc_timer_bank #(
   parameter int NUM_TIMERS = 4,
   parameter int CNT_W      = 10,
   parameter int DIV_W      = 4,
   parameter int SEL_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [SEL_W-1:0]      cfg_sel,
   input  logic [1:0]            cfg_addr,
   input  logic [CNT_W-1:0]      cfg_wdata,
   output logic [CNT_W-1:0]      cfg_rdata,
   input  logic [NUM_TIMERS-1:0] en_set,
   input  logic [NUM_TIMERS-1:0] en_clr,
   input  logic [NUM_TIMERS-1:0] gate,
   output logic [NUM_TIMERS-1:0] tmr_out,
   output logic [NUM_TIMERS-1:0] active,
   output logic [NUM_TIMERS-1:0] done
);

   // The prescaler must reach 2**div-1 for the largest div value.
   localparam int PRE_W = (1 << DIV_W) - 1;

   typedef enum logic [1:0] {
      MODE_CYCLE   = 2'd0,
      MODE_ONESHOT = 2'd1,
      MODE_TON     = 2'd2,
      MODE_TOF     = 2'd3
   } mode_e;

   typedef enum logic {
      PH_A = 1'b0,
      PH_B = 1'b1
   } phase_e;

   typedef struct packed {
      logic [CNT_W-1:0] period_a;
      logic [CNT_W-1:0] period_b;
      logic [DIV_W-1:0] div;
      mode_e            mode;
      logic             en;
      phase_e           phase;
      logic [CNT_W-1:0] cnt;
      logic [PRE_W-1:0] pre;
      logic             out;
   } chan_t;

   localparam chan_t CHAN_RST = '{
      period_a: CNT_W'(1),
      period_b: CNT_W'(2),
      div:      '0,
      mode:     MODE_CYCLE,
      en:       1'b0,
      phase:    PH_A,
      cnt:      '0,
      pre:      '0,
      out:      1'b0
   };

   logic [NUM_TIMERS*CNT_W-1:0] rd_flat;

   for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
      chan_t            c_q, c_n;
      logic             done_q, done_n;
      logic             wr_sel, timing, tick, phase_end;
      logic [CNT_W-1:0] period;
      logic [PRE_W-1:0] pre_max;
      logic [CNT_W-1:0] rd_word;

      assign wr_sel    = cfg_we && (cfg_sel == SEL_W'(g));
      // Wraps to all-ones when div selects the full prescaler width.
      assign pre_max   = (PRE_W'(1) << c_q.div) - PRE_W'(1);
      assign tick      = timing && (c_q.pre == pre_max);
      assign period    = (c_q.phase == PH_A) ? c_q.period_a : c_q.period_b;
      // >= so that a period lowered below the running count ends the phase.
      assign phase_end = tick && (c_q.cnt >= period);

      // A channel is timing exactly when it is active.
      always_comb begin
         timing = 1'b0;
         case (c_q.mode)
            MODE_TON: timing = c_q.en & gate[g] & ~c_q.out;
            MODE_TOF: timing = c_q.en & ~gate[g] & c_q.out;
            default:  timing = c_q.en;
         endcase
      end

      // Next-state: timing update, then config write, then enable/disable.
      always_comb begin
         // NOTE: every field starts at its current value so no path leaves a
         // variable unassigned, which would otherwise infer a latch.
         c_n    = c_q;
         done_n = 1'b0;
         c_n.pre = (timing && !tick) ? c_q.pre + PRE_W'(1) : '0;

         if (tick) begin
            if (phase_end) begin
               c_n.cnt = '0;
               done_n  = 1'b1;
               unique case (c_q.mode)
                  MODE_CYCLE, MODE_ONESHOT: begin
                     if (c_q.phase == PH_A) begin
                        c_n.phase = PH_B;
                        c_n.out   = 1'b0;
                        done_n    = 1'b0;
                     end else begin
                        c_n.phase = PH_A;
                        c_n.out   = (c_q.mode == MODE_CYCLE);
                        c_n.en    = (c_q.mode == MODE_CYCLE);
                     end
                  end
                  MODE_TON: c_n.out = 1'b1;
                  MODE_TOF: begin
                     c_n.out   = 1'b0;
                     c_n.phase = PH_A;
                  end
               endcase
            end else begin
               c_n.cnt = c_q.cnt + CNT_W'(1);
            end
         end

         // Level-driven modes: gate low drops TON, gate high (re)arms TOF.
         if (c_q.en && (c_q.mode == MODE_TON) && !gate[g]) begin
            c_n.out = 1'b0;
            c_n.cnt = '0;
         end
         if (c_q.en && (c_q.mode == MODE_TOF) && gate[g]) begin
            c_n.out   = 1'b1;
            c_n.cnt   = '0;
            c_n.phase = PH_B;
         end

         if (wr_sel) begin
            case (cfg_addr)
               2'd0: c_n.period_a = cfg_wdata;
               2'd1: c_n.period_b = cfg_wdata;
               2'd2: begin
                  c_n.div   = cfg_wdata[DIV_W+1:2];
                  c_n.mode  = mode_e'(cfg_wdata[1:0]);
                  c_n.en    = 1'b0;
                  c_n.out   = 1'b0;
                  c_n.cnt   = '0;
                  c_n.phase = PH_A;
                  c_n.pre   = '0;
                  done_n    = 1'b0;
               end
               default: ;
            endcase
         end

         // The enable sees the post-write mode, so a mode write plus en_set
         // starts the channel in the new mode.
         if (en_clr[g]) begin
            c_n.en    = 1'b0;
            c_n.out   = 1'b0;
            c_n.cnt   = '0;
            c_n.phase = PH_A;
            c_n.pre   = '0;
            done_n    = 1'b0;
         end else if (en_set[g] && !c_n.en) begin
            c_n.en    = 1'b1;
            c_n.cnt   = '0;
            c_n.phase = PH_A;
            c_n.pre   = '0;
            c_n.out   = (c_n.mode == MODE_CYCLE) || (c_n.mode == MODE_ONESHOT);
         end
      end

      always_ff @(posedge clk) begin
         // NOTE: config registers are plain flops, so they are reset along
         // with the counters; reset also drops any pending done.
         if (rst) begin
            c_q    <= CHAN_RST;
            done_q <= 1'b0;
         end else begin
            // NOTE: registered state uses non-blocking assignment only.
            c_q    <= c_n;
            done_q <= done_n;
         end
      end

      always_comb begin
         rd_word = '0;
         case (cfg_addr)
            2'd0: rd_word = c_q.period_a;
            2'd1: rd_word = c_q.period_b;
            2'd2: rd_word[DIV_W+1:0] = {c_q.div, c_q.mode};
            2'd3: rd_word[2:0] = {c_q.phase, c_q.en, c_q.out};
         endcase
      end

      assign rd_flat[g*CNT_W +: CNT_W] = rd_word;
      assign tmr_out[g] = c_q.out;
      assign active[g]  = timing;
      assign done[g]    = done_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_rdata <= '0;
      end else begin
         cfg_rdata <= '0;
         for (int i = 0; i < NUM_TIMERS; i++) begin
            if (cfg_sel == SEL_W'(i)) cfg_rdata <= rd_flat[i*CNT_W +: CNT_W];
         end
      end
   end

endmodule
